// File: rtl/arp_eth_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// arp_eth_rx
//
// ARP frame receiver. Takes a decoded Ethernet frame (header fields in parallel
// plus an AXI-stream payload) and extracts the 28-byte ARP body into parallel
// output fields, presented on a single valid/ready frame handshake. Payload
// bytes after the 28-byte body (Ethernet padding) are consumed and discarded.
//
// Parameters
//   DATA_WIDTH   payload width in bits (8, 16, 32, 64)
//   KEEP_ENABLE  honour tkeep; when 0 every lane is treated as valid
//   KEEP_WIDTH   bytes per payload beat
//
// Ports
//   clk, rst                  clock / asynchronous active-low reset
//   s_eth_hdr_*               Ethernet header handshake and fields
//   s_eth_payload_axis_*      Ethernet payload stream (byte 0 in bits [7:0])
//   m_frame_valid/ready       ARP frame handshake
//   m_eth_*                   Ethernet fields latched with the frame
//   m_arp_*                   decoded ARP fields
//   busy                      high while a frame payload is being consumed
//   error_header_early_termination  pulse: tlast before the body completed
//   error_invalid_header            pulse: body failed validation or tuser set
//
// Build option
//   ARP_RX_CHECK_TYPE_EN  when defined, also require ethertype 0x0806,
//                         htype 0x0001 and ptype 0x0800; otherwise only
//                         hlen == 6 and plen == 4 are checked.
// -----------------------------------------------------------------------------
module arp_eth_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,

  output logic                  m_frame_valid,
  input  logic                  m_frame_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [15:0]           m_arp_htype,
  output logic [15:0]           m_arp_ptype,
  output logic [7:0]            m_arp_hlen,
  output logic [7:0]            m_arp_plen,
  output logic [15:0]           m_arp_oper,
  output logic [47:0]           m_arp_sha,
  output logic [31:0]           m_arp_spa,
  output logic [47:0]           m_arp_tha,
  output logic [31:0]           m_arp_tpa,

  output logic                  busy,
  output logic                  error_header_early_termination,
  output logic                  error_invalid_header
);

  localparam int HDR_BYTES = 28;
  localparam int HDR_BEATS = (HDR_BYTES + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int PTR_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam int LAST_PTR  = (HDR_BYTES - 1) / KEEP_WIDTH;

  typedef enum logic [1:0] {IDLE, READ_HEADER, DROP} state_t;

  state_t                  state;
  logic [PTR_W-1:0]        ptr;
  // Wire byte k of the ARP body lives at bits [8*(27-k) +: 8], so the fields
  // fall out as plain big-endian slices.
  logic [8*HDR_BYTES-1:0]  hdr_q;
  logic [KEEP_WIDTH-1:0]   keep;
  logic                    beat;
  logic                    last_hdr_beat;
  logic                    hdr_ok;

  assign keep          = KEEP_ENABLE ? s_eth_payload_axis_tkeep : '1;
  assign beat          = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
  assign last_hdr_beat = (ptr == PTR_W'(LAST_PTR));

  // Header is taken as soon as the previous frame is gone or leaving this cycle.
  assign s_eth_hdr_ready = rst && (state == IDLE) && (!m_frame_valid || m_frame_ready);
  assign s_eth_payload_axis_tready = rst && (state != IDLE);
  assign busy                      = rst && (state != IDLE);

  assign m_arp_htype = hdr_q[223:208];
  assign m_arp_ptype = hdr_q[207:192];
  assign m_arp_hlen  = hdr_q[191:184];
  assign m_arp_plen  = hdr_q[183:176];
  assign m_arp_oper  = hdr_q[175:160];
  assign m_arp_sha   = hdr_q[159:112];
  assign m_arp_spa   = hdr_q[111:80];
  assign m_arp_tha   = hdr_q[79:32];
  assign m_arp_tpa   = hdr_q[31:0];

  // Length bytes arrive in an earlier beat than the final one for every
  // supported width, so the registered copy is complete when this is used.
  always_comb begin
    hdr_ok = (m_arp_hlen == 8'd6) && (m_arp_plen == 8'd4);
`ifdef ARP_RX_CHECK_TYPE_EN
    hdr_ok = hdr_ok && (m_eth_type == 16'h0806) &&
             (m_arp_htype == 16'h0001) && (m_arp_ptype == 16'h0800);
`else
    hdr_ok = hdr_ok;
`endif
  end

  // NOTE: every register below uses non-blocking assignments so all updates
  // in this block see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                          <= IDLE;
      ptr                            <= '0;
      // NOTE: the body register is reset too; it drives outputs directly and
      // must read as zero out of reset, unlike a RAM-style store.
      hdr_q                          <= '0;
      m_eth_dest_mac                 <= '0;
      m_eth_src_mac                  <= '0;
      m_eth_type                     <= '0;
      m_frame_valid                  <= 1'b0;
      error_header_early_termination <= 1'b0;
      error_invalid_header           <= 1'b0;
    end else begin
      error_header_early_termination <= 1'b0;
      error_invalid_header           <= 1'b0;

      if (m_frame_valid && m_frame_ready) begin
        m_frame_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (s_eth_hdr_valid && s_eth_hdr_ready) begin
            m_eth_dest_mac <= s_eth_dest_mac;
            m_eth_src_mac  <= s_eth_src_mac;
            m_eth_type     <= s_eth_type;
            ptr            <= '0;
            state          <= READ_HEADER;
          end
        end

        READ_HEADER: begin
          if (beat) begin
            for (int k = 0; k < HDR_BYTES; k++) begin
              if ((ptr == PTR_W'(k / KEEP_WIDTH)) && keep[k % KEEP_WIDTH]) begin
                hdr_q[(HDR_BYTES-1-k)*8 +: 8] <=
                  s_eth_payload_axis_tdata[(k % KEEP_WIDTH)*8 +: 8];
              end
            end
            ptr <= ptr + 1'b1;

            if (last_hdr_beat) begin
              if (!s_eth_payload_axis_tuser && hdr_ok) begin
                m_frame_valid <= 1'b1;
              end else begin
                error_invalid_header <= 1'b1;
              end
              state <= s_eth_payload_axis_tlast ? IDLE : DROP;
            end else if (s_eth_payload_axis_tlast) begin
              error_header_early_termination <= 1'b1;
              state                          <= IDLE;
            end
          end
        end

        DROP: begin
          if (beat && s_eth_payload_axis_tlast) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_eth_rx.sv
`timescale 1ns/1ps
// Directed testbench for arp_eth_rx: an 8-bit instance carries most scenarios,
// a 64-bit instance checks lane extraction with tkeep and tvalid gaps.
module tb_arp_eth_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [47:0] E_DEST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] E_SRC  = 48'h5A5152535455;
  localparam logic [15:0] E_TYPE = 16'h0806;

  // ---------------- 8-bit instance ----------------
  logic        a_hdr_valid, a_hdr_ready;
  logic [7:0]  a_tdata;
  logic [0:0]  a_tkeep;
  logic        a_tvalid, a_tready, a_tlast, a_tuser;
  logic        a_fvalid, a_fready;
  logic [47:0] a_m_dest, a_m_src;
  logic [15:0] a_m_type, a_htype, a_ptype, a_oper;
  logic [7:0]  a_hlen, a_plen;
  logic [47:0] a_sha, a_tha;
  logic [31:0] a_spa, a_tpa;
  logic        a_busy, a_err_early, a_err_inv;
  logic [223:0] a_hdr;
  assign a_hdr = {a_htype, a_ptype, a_hlen, a_plen, a_oper, a_sha, a_spa, a_tha, a_tpa};

  arp_eth_rx #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(a_hdr_valid), .s_eth_hdr_ready(a_hdr_ready),
    .s_eth_dest_mac(E_DEST), .s_eth_src_mac(E_SRC), .s_eth_type(E_TYPE),
    .s_eth_payload_axis_tdata(a_tdata), .s_eth_payload_axis_tkeep(a_tkeep),
    .s_eth_payload_axis_tvalid(a_tvalid), .s_eth_payload_axis_tready(a_tready),
    .s_eth_payload_axis_tlast(a_tlast), .s_eth_payload_axis_tuser(a_tuser),
    .m_frame_valid(a_fvalid), .m_frame_ready(a_fready),
    .m_eth_dest_mac(a_m_dest), .m_eth_src_mac(a_m_src), .m_eth_type(a_m_type),
    .m_arp_htype(a_htype), .m_arp_ptype(a_ptype), .m_arp_hlen(a_hlen),
    .m_arp_plen(a_plen), .m_arp_oper(a_oper), .m_arp_sha(a_sha), .m_arp_spa(a_spa),
    .m_arp_tha(a_tha), .m_arp_tpa(a_tpa),
    .busy(a_busy), .error_header_early_termination(a_err_early),
    .error_invalid_header(a_err_inv)
  );

  // ---------------- 64-bit instance ----------------
  logic        w_hdr_valid, w_hdr_ready;
  logic [63:0] w_tdata;
  logic [7:0]  w_tkeep;
  logic        w_tvalid, w_tready, w_tlast, w_tuser;
  logic        w_fvalid, w_fready;
  logic [47:0] w_m_dest, w_m_src;
  logic [15:0] w_m_type, w_htype, w_ptype, w_oper;
  logic [7:0]  w_hlen, w_plen;
  logic [47:0] w_sha, w_tha;
  logic [31:0] w_spa, w_tpa;
  logic        w_busy, w_err_early, w_err_inv;
  logic [223:0] w_hdr;
  assign w_hdr = {w_htype, w_ptype, w_hlen, w_plen, w_oper, w_sha, w_spa, w_tha, w_tpa};

  arp_eth_rx #(.DATA_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(w_hdr_valid), .s_eth_hdr_ready(w_hdr_ready),
    .s_eth_dest_mac(E_DEST), .s_eth_src_mac(E_SRC), .s_eth_type(E_TYPE),
    .s_eth_payload_axis_tdata(w_tdata), .s_eth_payload_axis_tkeep(w_tkeep),
    .s_eth_payload_axis_tvalid(w_tvalid), .s_eth_payload_axis_tready(w_tready),
    .s_eth_payload_axis_tlast(w_tlast), .s_eth_payload_axis_tuser(w_tuser),
    .m_frame_valid(w_fvalid), .m_frame_ready(w_fready),
    .m_eth_dest_mac(w_m_dest), .m_eth_src_mac(w_m_src), .m_eth_type(w_m_type),
    .m_arp_htype(w_htype), .m_arp_ptype(w_ptype), .m_arp_hlen(w_hlen),
    .m_arp_plen(w_plen), .m_arp_oper(w_oper), .m_arp_sha(w_sha), .m_arp_spa(w_spa),
    .m_arp_tha(w_tha), .m_arp_tpa(w_tpa),
    .busy(w_busy), .error_header_early_termination(w_err_early),
    .error_invalid_header(w_err_inv)
  );

  // Error pulse counters, sampled on the active edge (pre-update values).
  int cnt_a_early = 0, cnt_a_inv = 0, cnt_w_early = 0, cnt_w_inv = 0;
  always @(posedge clk) begin
    if (a_err_early) cnt_a_early++;
    if (a_err_inv)   cnt_a_inv++;
    if (w_err_early) cnt_w_early++;
    if (w_err_inv)   cnt_w_inv++;
  end

  // Frame byte buffer in wire order.
  logic [7:0] fb [64];

  // ARP body: htype 1, oper 1 (request), sha 5A:51:52:53:54:55,
  // spa 192.168.1.100, tha 0, tpa 192.168.1.1; hlen/ptype selectable.
  function automatic logic [223:0] mk_hdr(input logic [7:0] hlen, input logic [15:0] ptype);
    return {16'h0001, ptype, hlen, 8'd4, 16'h0001, 48'h5A5152535455,
            32'hC0A80164, 48'h000000000000, 32'hC0A80101};
  endfunction

  task automatic load_frame(input logic [223:0] h, input int len);
    for (int k = 0; k < len; k++) begin
      fb[k] = (k < 28) ? h[223-8*k -: 8] : 8'(8'h40 + k);
    end
  endtask

  task automatic a_send_hdr();
    int t;
    t = 0;
    a_hdr_valid = 1'b1;
    while (!a_hdr_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL a_hdr_timeout: s_eth_hdr_ready stayed %0b for 50 cycles", a_hdr_ready);
    end
    @(posedge clk); @(negedge clk);
    a_hdr_valid = 1'b0;
  endtask

  task automatic a_send_bytes(input int n, input logic with_last, input logic with_user,
                              output logic v27);
    v27 = 1'b0;
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      a_tdata  = fb[i];
      a_tvalid = 1'b1;
      a_tlast  = with_last && (i == n - 1);
      a_tuser  = with_user && (i == n - 1);
      while (!a_tready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin
        checks++; errors++;
        $display("FAIL a_tready_timeout: byte %0d, tready %0b for 50 cycles", i, a_tready);
      end
      @(posedge clk); @(negedge clk);
      if (i == 27) v27 = a_fvalid;
    end
    a_tvalid = 1'b0; a_tlast = 1'b0; a_tuser = 1'b0;
  endtask

  task automatic a_accept();
    a_fready = 1'b1;
    @(posedge clk); @(negedge clk);
    a_fready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++;
    if ({a_hdr_ready, a_tready, a_fvalid, a_busy, a_err_early, a_err_inv} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl8: got %b expected 000000",
               {a_hdr_ready, a_tready, a_fvalid, a_busy, a_err_early, a_err_inv});
    end
    checks++;
    if ({a_hdr, a_m_dest, a_m_src, a_m_type} !== '0) begin
      errors++; $display("FAIL reset_fields8: got %h expected 0", a_hdr);
    end
    checks++;
    if ({w_hdr_ready, w_tready, w_fvalid, w_busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl64: got %b expected 0000", {w_hdr_ready, w_tready, w_fvalid, w_busy});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (a_hdr_ready !== 1'b1) begin
      errors++; $display("FAIL idle_hdr_ready: got %0b expected 1", a_hdr_ready);
    end
  endtask

  task automatic test_basic();
    logic v;
    cnt_a_early = 0; cnt_a_inv = 0;
    load_frame(mk_hdr(8'd6, 16'h0800), 28);
    a_send_hdr();
    a_send_bytes(28, 1'b1, 1'b0, v);
    checks++;
    if (v !== 1'b1) begin errors++; $display("FAIL basic_valid_latency: got %0b expected 1", v); end
    checks++;
    if (a_hdr !== mk_hdr(8'd6, 16'h0800)) begin
      errors++; $display("FAIL basic_fields: got %h expected %h", a_hdr, mk_hdr(8'd6, 16'h0800));
    end
    checks++;
    if ({a_m_dest, a_m_src, a_m_type} !== {E_DEST, E_SRC, E_TYPE}) begin
      errors++; $display("FAIL basic_eth: got %h expected %h", {a_m_dest, a_m_src, a_m_type},
                         {E_DEST, E_SRC, E_TYPE});
    end
    checks++;
    if (cnt_a_early != 0 || cnt_a_inv != 0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL basic_status: early %0d inv %0d busy %0b expected 0 0 0",
                         cnt_a_early, cnt_a_inv, a_busy);
    end
    a_accept();
    checks++;
    if (a_fvalid !== 1'b0) begin errors++; $display("FAIL basic_accept: got %0b expected 0", a_fvalid); end
  endtask

  task automatic test_backpressure();
    logic v;
    load_frame(mk_hdr(8'd6, 16'h0800), 46);
    a_send_hdr();
    a_send_bytes(46, 1'b1, 1'b0, v);
    checks++;
    if (v !== 1'b1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL pad_valid_busy: valid %0b busy %0b expected 1 0", v, a_busy);
    end
    a_hdr_valid = 1'b1;   // next header waits behind the pending frame
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (a_hdr !== mk_hdr(8'd6, 16'h0800) || a_fvalid !== 1'b1 || a_hdr_ready !== 1'b0) begin
        errors++; $display("FAIL hold_cycle%0d: valid %0b hdr_ready %0b fields %h", c,
                           a_fvalid, a_hdr_ready, a_hdr);
      end
      @(negedge clk);
    end
    a_fready = 1'b1;
    #1;
    checks++;
    if (a_hdr_ready !== 1'b1) begin
      errors++; $display("FAIL hdr_ready_on_accept: got %0b expected 1", a_hdr_ready);
    end
    @(posedge clk); @(negedge clk);
    a_fready = 1'b0; a_hdr_valid = 1'b0;
    checks++;
    if (a_fvalid !== 1'b0 || a_busy !== 1'b1) begin
      errors++; $display("FAIL back_to_back_hdr: valid %0b busy %0b expected 0 1", a_fvalid, a_busy);
    end
    load_frame(mk_hdr(8'd6, 16'h0800), 28);
    a_send_bytes(28, 1'b1, 1'b0, v);
    checks++;
    if (v !== 1'b1) begin errors++; $display("FAIL back_to_back_valid: got %0b expected 1", v); end
    a_accept();
  endtask

  task automatic test_early_term();
    logic v;
    cnt_a_early = 0; cnt_a_inv = 0;
    load_frame(mk_hdr(8'd6, 16'h0800), 28);
    a_send_hdr();
    a_send_bytes(21, 1'b1, 1'b0, v);
    repeat (3) @(negedge clk);
    checks++;
    if (cnt_a_early != 1 || cnt_a_inv != 0 || a_fvalid !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL early_term: pulses %0d inv %0d valid %0b busy %0b expected 1 0 0 0",
                         cnt_a_early, cnt_a_inv, a_fvalid, a_busy);
    end
    test_basic();
  endtask

  task automatic test_invalid();
    logic v;
    cnt_a_early = 0; cnt_a_inv = 0;
    load_frame(mk_hdr(8'd8, 16'h0800), 28);
    a_send_hdr();
    a_send_bytes(28, 1'b1, 1'b0, v);
    @(negedge clk);
    checks++;
    if (v !== 1'b0 || a_fvalid !== 1'b0 || cnt_a_inv != 1 || cnt_a_early != 0) begin
      errors++; $display("FAIL invalid_hlen: valid %0b/%0b inv %0d early %0d expected 0/0 1 0",
                         v, a_fvalid, cnt_a_inv, cnt_a_early);
    end
    cnt_a_inv = 0;
    load_frame(mk_hdr(8'd6, 16'h0800), 28);
    a_send_hdr();
    a_send_bytes(28, 1'b1, 1'b1, v);
    @(negedge clk);
    checks++;
    if (v !== 1'b0 || cnt_a_inv != 1) begin
      errors++; $display("FAIL invalid_tuser: valid %0b inv %0d expected 0 1", v, cnt_a_inv);
    end
    cnt_a_inv = 0;
    load_frame(mk_hdr(8'd6, 16'h86DD), 28);
    a_send_hdr();
    a_send_bytes(28, 1'b1, 1'b0, v);
    @(negedge clk);
`ifdef ARP_RX_CHECK_TYPE_EN
    checks++;
    if (v !== 1'b0 || cnt_a_inv != 1) begin
      errors++; $display("FAIL invalid_ptype: valid %0b inv %0d expected 0 1", v, cnt_a_inv);
    end
`else
    checks++;
    if (v !== 1'b1 || cnt_a_inv != 0 || a_ptype !== 16'h86DD) begin
      errors++; $display("FAIL ptype_passthrough: valid %0b inv %0d ptype %h expected 1 0 86dd",
                         v, cnt_a_inv, a_ptype);
    end
    a_accept();
`endif
  endtask

  task automatic test_reset_mid();
    logic v;
    load_frame(mk_hdr(8'd6, 16'h0800), 28);
    a_send_hdr();
    a_send_bytes(10, 1'b0, 1'b0, v);
    rst = 1'b0;
    #1;
    checks++;
    if ({a_hdr_ready, a_tready, a_fvalid, a_busy} !== 4'b0 || a_hdr !== '0 || a_m_dest !== '0) begin
      errors++; $display("FAIL reset_mid: ctrl %b hdr %h dest %h expected 0",
                         {a_hdr_ready, a_tready, a_fvalid, a_busy}, a_hdr, a_m_dest);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_basic();
  endtask

  task automatic test_wide();
    logic v2, v3;
    int t;
    cnt_w_early = 0; cnt_w_inv = 0;
    load_frame(mk_hdr(8'd6, 16'h0800), 28);
    t = 0;
    w_hdr_valid = 1'b1;
    while (!w_hdr_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      checks++; errors++; $display("FAIL w_hdr_timeout: hdr_ready %0b for 50 cycles", w_hdr_ready);
    end
    @(posedge clk); @(negedge clk);
    w_hdr_valid = 1'b0;
    v2 = 1'b0; v3 = 1'b0;
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        w_tdata[8*i +: 8] = (8*b + i < 28) ? fb[8*b + i] : 8'hEE;
      end
      w_tkeep  = (b == 3) ? 8'h0F : 8'hFF;
      w_tlast  = (b == 3);
      w_tvalid = 1'b1;
      t = 0;
      while (!w_tready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin
        checks++; errors++; $display("FAIL w_tready_timeout: beat %0d tready %0b", b, w_tready);
      end
      @(posedge clk); @(negedge clk);
      w_tvalid = 1'b0; w_tlast = 1'b0;
      if (b == 2) v2 = w_fvalid;
      if (b == 3) v3 = w_fvalid;
    end
    checks++;
    if (v2 !== 1'b0 || v3 !== 1'b1) begin
      errors++; $display("FAIL wide_latency: before last %0b after last %0b expected 0 1", v2, v3);
    end
    checks++;
    if (w_hdr !== mk_hdr(8'd6, 16'h0800) || {w_m_dest, w_m_src, w_m_type} !== {E_DEST, E_SRC, E_TYPE}) begin
      errors++; $display("FAIL wide_fields: got %h expected %h", w_hdr, mk_hdr(8'd6, 16'h0800));
    end
    checks++;
    if (cnt_w_early != 0 || cnt_w_inv != 0 || w_busy !== 1'b0) begin
      errors++; $display("FAIL wide_status: early %0d inv %0d busy %0b expected 0 0 0",
                         cnt_w_early, cnt_w_inv, w_busy);
    end
    w_fready = 1'b1;
    @(posedge clk); @(negedge clk);
    w_fready = 1'b0;
    checks++;
    if (w_fvalid !== 1'b0) begin errors++; $display("FAIL wide_accept: got %0b expected 0", w_fvalid); end
  endtask

  initial begin
    a_hdr_valid = 0; a_tdata = 0; a_tkeep = 1'b1; a_tvalid = 0; a_tlast = 0; a_tuser = 0; a_fready = 0;
    w_hdr_valid = 0; w_tdata = 0; w_tkeep = 8'hFF; w_tvalid = 0; w_tlast = 0; w_tuser = 0; w_fready = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_early_term();
    test_invalid();
    test_wide();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
